// File: rtl/scarv_uart_rx_fifo.sv
// rtl/scarv_uart_rx_fifo.sv - UART receiver with byte storage (FIFO when SCARV_UART_RX_FIFO_EN is defined)
// Default build keeps one holding register; `define SCARV_UART_RX_FIFO_EN for a FIFO_DEPTH-entry FIFO.
module scarv_uart_rx_fifo #(
    parameter int UART_BIT_RATE  = 256_000,
    parameter int UART_CLK_HZ    = 50_000_000,
    parameter int UART_STOP_BITS = 1,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       f_clk,
    input  logic       g_reset,
    input  logic       uart_rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic       rx_overrun,
    output logic       rx_frame_err
);

    localparam int CPB  = UART_CLK_HZ / UART_BIT_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB) + 1;
    localparam logic [CW-1:0] CPB_LAST  = CW'(CPB - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);
    localparam logic          STOP_LAST = 1'(UART_STOP_BITS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic          stop_idx;
    logic [7:0]    shreg;
    logic          push_pend;
    logic          sync1;
    logic          rxs;
    logic          rxs_q;
    logic          pop;

    // shreg stays stable in IDLE, so the storage side can take it the cycle after the last stop sample.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            state        <= IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= 8'h00;
            push_pend    <= 1'b0;
            rx_frame_err <= 1'b0;
            sync1        <= 1'b1;
            rxs          <= 1'b1;
            rxs_q        <= 1'b1;
        end else begin
            sync1        <= uart_rxd;
            rxs          <= sync1;
            rxs_q        <= rxs;
            push_pend    <= 1'b0;
            rx_frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (!rxs && rxs_q) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rxs ? IDLE : DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt == CPB_LAST) begin
                        cnt     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) begin
                            state    <= STOP;
                            stop_idx <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt == CPB_LAST) begin
                        cnt <= '0;
                        if (!rxs) begin
                            rx_frame_err <= 1'b1;
                            state        <= IDLE;
                        end else if (stop_idx == STOP_LAST) begin
                            push_pend <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            stop_idx <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign pop = rx_valid && rx_ready;

`ifdef SCARV_UART_RX_FIFO_EN
    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        full;

    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rx_valid = (wr_ptr != rd_ptr);
    assign rx_data  = mem[rd_ptr[AW-1:0]];

    // When full, a same-cycle pop frees the head slot, which is exactly where the write lands.
    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            rx_overrun <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'h00;
        end else begin
            rx_overrun <= 1'b0;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (push_pend) begin
                if (!full || pop) begin
                    mem[wr_ptr[AW-1:0]] <= shreg;
                    wr_ptr              <= wr_ptr + 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end
        end
    end
`else
    logic       full;
    logic [7:0] hold;

    assign rx_valid = full;
    assign rx_data  = hold;

    always_ff @(posedge f_clk) begin
        if (g_reset) begin
            full       <= 1'b0;
            hold       <= 8'h00;
            rx_overrun <= 1'b0;
        end else begin
            rx_overrun <= 1'b0;
            if (push_pend) begin
                if (!full || pop) begin
                    hold <= shreg;
                    full <= 1'b1;
                end else begin
                    rx_overrun <= 1'b1;
                end
            end else if (pop) begin
                full <= 1'b0;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scarv_uart_rx_fifo.sv
// tb/tb_scarv_uart_rx_fifo.sv - directed self-checking bench for scarv_uart_rx_fifo
module tb_scarv_uart_rx_fifo;

    localparam int CPB = 195;
`ifdef SCARV_UART_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic       f_clk = 1'b0;
    logic       g_reset = 1'b1;
    logic       uart_rxd = 1'b1;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready = 1'b0;
    logic       rx_overrun;
    logic       rx_frame_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] popped[$];
    int valid_cycles = 0;
    int ov_cnt = 0;
    int fe_cnt = 0;

    int p0, v0, o0, f0;

    scarv_uart_rx_fifo dut (
        .f_clk       (f_clk),
        .g_reset     (g_reset),
        .uart_rxd    (uart_rxd),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .rx_overrun  (rx_overrun),
        .rx_frame_err(rx_frame_err)
    );

    always #5 f_clk = ~f_clk;

    always @(negedge f_clk) begin
        if (rx_valid && rx_ready) popped.push_back(rx_data);
        if (rx_valid) valid_cycles++;
        if (rx_overrun) ov_cnt++;
        if (rx_frame_err) fe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic snap();
        p0 = popped.size();
        v0 = valid_cycles;
        o0 = ov_cnt;
        f0 = fe_cnt;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        @(posedge f_clk);
        #1 uart_rxd = 1'b0;
        repeat (CPB) @(posedge f_clk);
        for (int i = 0; i < 8; i++) begin
            #1 uart_rxd = b[i];
            repeat (CPB) @(posedge f_clk);
        end
        #1 uart_rxd = stop_bit;
        repeat (CPB) @(posedge f_clk);
        #1 uart_rxd = 1'b1;
        repeat (CPB) @(posedge f_clk);
    endtask

    initial begin
        logic [7:0] fill [4];
        fill[0] = 8'h11; fill[1] = 8'h22; fill[2] = 8'h33; fill[3] = 8'h44;

        repeat (3) @(posedge f_clk);
        #1 g_reset = 1'b0;
        check("reset_valid", 32'(rx_valid), 32'd0);
        check("reset_data", 32'(rx_data), 32'h00);
        check("reset_overrun", 32'(rx_overrun), 32'd0);
        check("reset_frame_err", 32'(rx_frame_err), 32'd0);
        repeat (20) @(posedge f_clk);

        // Normal byte with consumer ready
        rx_ready = 1'b1;
        snap();
        send_byte(8'hA5, 1'b1);
        repeat (50) @(posedge f_clk);
        check("a5_pops", 32'(popped.size() - p0), 32'd1);
        if (popped.size() > p0) check("a5_data", 32'(popped[p0]), 32'hA5);
        check("a5_valid_cycles", 32'(valid_cycles - v0), 32'd1);
        check("a5_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("a5_overrun", 32'(ov_cnt - o0), 32'd0);

        // Short low glitch is rejected
        snap();
        @(posedge f_clk);
        #1 uart_rxd = 1'b0;
        repeat (50) @(posedge f_clk);
        #1 uart_rxd = 1'b1;
        repeat (400) @(posedge f_clk);
        check("glitch_valid", 32'(valid_cycles - v0), 32'd0);
        check("glitch_frame_err", 32'(fe_cnt - f0), 32'd0);
        check("glitch_overrun", 32'(ov_cnt - o0), 32'd0);

        // Bad stop bit
        snap();
        send_byte(8'h3C, 1'b0);
        repeat (50) @(posedge f_clk);
        check("frame_err_pulses", 32'(fe_cnt - f0), 32'd1);
        check("frame_err_valid", 32'(valid_cycles - v0), 32'd0);

        // Overrun with consumer stalled
        rx_ready = 1'b0;
        snap();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'(i), 1'b1);
            repeat (20) @(posedge f_clk);
        end
        check("ovr_pulses", 32'(ov_cnt - o0), 32'(5 - DEPTH));
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_head", 32'(rx_data), 32'h01);
        @(posedge f_clk);
        #1 rx_ready = 1'b1;
        repeat (10) @(posedge f_clk);
        #1 rx_ready = 1'b0;
        check("ovr_pops", 32'(popped.size() - p0), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++)
            if (popped.size() > p0 + i) check("ovr_pop_data", 32'(popped[p0 + i]), 32'(i + 1));
        check("ovr_empty", 32'(rx_valid), 32'd0);

        // Reset in the middle of data bit 4 of 0xFF
        rx_ready = 1'b1;
        snap();
        @(posedge f_clk);
        #1 uart_rxd = 1'b0;
        repeat (CPB) @(posedge f_clk);
        #1 uart_rxd = 1'b1;
        repeat (4 * CPB + 100) @(posedge f_clk);
        #1 g_reset = 1'b1;
        @(posedge f_clk);
        #1 g_reset = 1'b0;
        check("rst_mid_valid", 32'(rx_valid), 32'd0);
        repeat (5 * CPB) @(posedge f_clk);
        send_byte(8'h5A, 1'b1);
        repeat (50) @(posedge f_clk);
        check("rst_mid_pops", 32'(popped.size() - p0), 32'd1);
        if (popped.size() > p0) check("rst_mid_data", 32'(popped[p0]), 32'h5A);
        check("rst_mid_frame_err", 32'(fe_cnt - f0), 32'd0);

        // Storage full, consumer starts on exactly the push cycle
        rx_ready = 1'b0;
        snap();
        for (int i = 0; i < DEPTH; i++) begin
            send_byte(fill[i], 1'b1);
            repeat (20) @(posedge f_clk);
        end
        check("full_valid", 32'(rx_valid), 32'd1);
        fork
            send_byte(8'h55, 1'b1);
            begin
                @(posedge f_clk);
                repeat (1855) @(posedge f_clk);
                #1 rx_ready = 1'b1;
            end
        join
        repeat (20) @(posedge f_clk);
        check("full_overrun", 32'(ov_cnt - o0), 32'd0);
        check("full_pops", 32'(popped.size() - p0), 32'(DEPTH + 1));
        for (int i = 0; i < DEPTH; i++)
            if (popped.size() > p0 + i) check("full_order", 32'(popped[p0 + i]), 32'(fill[i]));
        if (popped.size() > p0 + DEPTH) check("full_last", 32'(popped[p0 + DEPTH]), 32'h55);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/scarv_uart_rx_fifo.md
SCARV_UART_RX_FIFO -- requirements
Module: scarv_uart_rx_fifo

Interface
REQ-001 The block SHALL have parameter UART_BIT_RATE, default 256_000, line bit rate in bits/sec.
REQ-002 The block SHALL have parameter UART_CLK_HZ, default 50_000_000, f_clk frequency in Hz.
REQ-003 The block SHALL have parameter UART_STOP_BITS, default 1, number of stop bits, legal values 1 or 2.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, byte capacity when SCARV_UART_RX_FIFO_EN is defined, power of two, 2..16.
REQ-005 The block SHALL have port f_clk, input, 1, free running clock; the block has this single clock domain.
REQ-006 The block SHALL have port g_reset, input, 1, global reset, synchronous, active-high.
REQ-007 The block SHALL have port uart_rxd, input, 1, asynchronous serial line, consumed from the SoC uart_txd output.
REQ-008 The block SHALL have port rx_valid, output, 1, received byte available at rx_data.
REQ-009 The block SHALL have port rx_data, output, 8, oldest received byte.
REQ-010 The block SHALL have port rx_ready, input, 1, consumer accepts rx_data.
REQ-011 The block SHALL have port rx_overrun, output, 1, one-cycle pulse when a completed byte is dropped because storage is full.
REQ-012 The block SHALL have port rx_frame_err, output, 1, one-cycle pulse on a bad stop bit.

Function
REQ-013 CPB (cycles per bit) SHALL be UART_CLK_HZ/UART_BIT_RATE with integer truncation, and HALF SHALL be CPB/2; the bit counter SHALL be clog2(CPB)+1 bits wide.
REQ-014 uart_rxd SHALL pass through a 2-flop synchroniser, reset value 1; all decisions SHALL use the synchronised value (rxs) and its one-cycle delayed copy (rxs_q).
REQ-015 The FSM SHALL have states IDLE, START, DATA and STOP.
REQ-016 IDLE->START SHALL occur when rxs==0 and rxs_q==1, with the counter cleared.
REQ-017 In START, at counter==HALF-1, the FSM SHALL go to DATA if rxs==0, and to IDLE otherwise (glitch rejected, no flags).
REQ-018 In DATA, rxs SHALL be sampled every CPB cycles, shifted LSB-first, and 8 samples taken before entering STOP.
REQ-019 In STOP, rxs SHALL be sampled every CPB cycles for UART_STOP_BITS samples.
REQ-020 If any stop sample is 0, rx_frame_err SHALL pulse on the cycle after that sample, the byte SHALL be discarded, and the FSM SHALL return to IDLE.
REQ-021 When all stop samples are 1, the byte SHALL be pushed on the cycle after the last sample and the FSM SHALL return to IDLE; rx_valid SHALL rise the following cycle if storage was empty.
REQ-022 A pop SHALL occur when rx_valid && rx_ready on a rising edge; rx_data SHALL always show the head entry, and rx_valid SHALL equal not-empty.
REQ-023 A push while full with no pop in the same cycle SHALL drop the byte, pulse rx_overrun and leave the stored contents unchanged.
REQ-024 A push and a pop in the same cycle SHALL both take effect, including when full, with no overrun.
REQ-025 Read and write pointers SHALL wrap modulo storage depth, with an extra MSB distinguishing full from empty.

Reset
REQ-026 On g_reset==1 at a rising f_clk, the FSM SHALL go to IDLE, counters and pointers to 0, and the synchroniser flops to 1.
REQ-027 Reset SHALL drive rx_valid=0, rx_data=8'h00, rx_overrun=0 and rx_frame_err=0.
REQ-028 Reset mid-frame SHALL abandon the partial byte; the next byte SHALL require a fresh falling edge.

Configuration
REQ-029 With SCARV_UART_RX_FIFO_EN defined, storage SHALL be a FIFO of FIFO_DEPTH entries.
REQ-030 Without SCARV_UART_RX_FIFO_EN, storage SHALL be a single holding register (depth 1) and FIFO_DEPTH SHALL be ignored; all handshake and overrun rules SHALL be unchanged.

Verification
REQ-031 Defaults (CPB=195): send 0xA5 at 256000 baud with rx_ready=1 -> one rx_valid cycle with rx_data=0xA5, rx_frame_err=0 and rx_overrun=0.
REQ-032 Pull uart_rxd low for 50 cycles, then high -> FSM returns to IDLE, and rx_valid, rx_frame_err and rx_overrun stay 0.
REQ-033 Send 0x3C with the stop bit forced to 0 -> rx_frame_err pulses once, and rx_valid stays 0.
REQ-034 FIFO_EN defined, rx_ready=0, send 0x01..0x05 -> 0x05 dropped with one rx_overrun pulse; then rx_ready=1 -> pops 0x01,0x02,0x03,0x04. Without FIFO_EN, same stimulus -> four overrun pulses and the pop yields 0x01.
REQ-035 Assert g_reset for 1 cycle during DATA bit 4 of 0xFF, then send 0x5A -> only 0x5A is delivered, and rx_valid=0 on the cycle after reset.
REQ-036 Full FIFO with rx_ready=1 held as a byte completes -> push and pop in the same cycle, no overrun, and order preserved.
